tile_match_engine: RTL and testbench

Parametrised in-game engine for the FPGA tile-matching game. It replaces the fixed single-player board logic with a configurable board size, symbol width, reveal delay and number of players taking turns. It sits between the game-mode FSM and the display/VGA path. It consumes tile selections and exposes the board masks, move count, per-player scores and the game-over flag.

---
 rtl/tile_match_engine.sv | 192 +++++++++++++++++++
 tb/tb_tile_match_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_match_engine.sv
// tile_match_engine: turn-based tile-matching game engine.
// Latches the board symbols on start, takes two tile picks per turn,
// scores matching pairs (bonus turn) and hides mismatches after a delay.
module tile_match_engine #(
   parameter int NUM_TILES     = 16,
   parameter int SYM_W         = 3,
   parameter int MOVE_W        = 8,
   parameter int NUM_PLAYERS   = 2,
   parameter int REVEAL_CYCLES = 50_000_000,
   localparam int IDX_W = $clog2(NUM_TILES),
   localparam int PL_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
   localparam int SC_W  = $clog2(NUM_TILES/2 + 1)
) (
   input  logic                         CLOCK_50,
   input  logic                         resetn,
   input  logic                         start,
   input  logic                         quit,
   input  logic                         sel_valid,
   input  logic [IDX_W-1:0]             sel_idx,
   input  logic [NUM_TILES*SYM_W-1:0]   tile_sym,
   output logic [NUM_TILES-1:0]         revealed,
   output logic [NUM_TILES-1:0]         matched,
   output logic [MOVE_W-1:0]            moves,
   output logic [PL_W-1:0]              player,
   output logic [NUM_PLAYERS*SC_W-1:0]  scores,
   output logic                         in_game,
   output logic                         game_over,
   output logic                         sel_err
);

   localparam int CNT_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_PICK1, S_PICK2, S_CHECK, S_SHOW, S_DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [NUM_TILES*SYM_W-1:0]    sym_q, sym_d;
   logic [IDX_W-1:0]              first_q, first_d;
   logic [IDX_W-1:0]              second_q, second_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [NUM_TILES-1:0]          revealed_q, revealed_d;
   logic [NUM_TILES-1:0]          matched_q, matched_d;
   logic [MOVE_W-1:0]             moves_q, moves_d;
   logic [PL_W-1:0]               player_q, player_d;
   logic [NUM_PLAYERS*SC_W-1:0]   scores_q, scores_d;
   logic                          sel_err_q, sel_err_d;

   logic                          pick_free;
   logic [SYM_W-1:0]              sym_first, sym_second;

   // Selection is usable only if it names a real, not-yet-matched tile
   always_comb begin
      pick_free = 1'b0;
      for (int unsigned i = 0; i < NUM_TILES; i++) begin
         if (sel_idx == IDX_W'(i) && !matched_q[i]) pick_free = 1'b1;
      end
      sym_first  = sym_q[first_q*SYM_W +: SYM_W];
      sym_second = sym_q[second_q*SYM_W +: SYM_W];
   end

   // Next-state and datapath updates; quit overrides everything else
   always_comb begin
      state_d    = state_q;
      sym_d      = sym_q;
      first_d    = first_q;
      second_d   = second_q;
      cnt_d      = cnt_q;
      revealed_d = revealed_q;
      matched_d  = matched_q;
      moves_d    = moves_q;
      player_d   = player_q;
      scores_d   = scores_q;
      sel_err_d  = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               sym_d      = tile_sym;
               revealed_d = '0;
               matched_d  = '0;
               moves_d    = '0;
               scores_d   = '0;
               player_d   = '0;
               state_d    = S_PICK1;
            end
         end
         S_PICK1: begin
            if (sel_valid) begin
               if (pick_free) begin
                  first_d             = sel_idx;
                  revealed_d[sel_idx] = 1'b1;
                  state_d             = S_PICK2;
               end else begin
                  sel_err_d = 1'b1;
               end
            end
         end
         S_PICK2: begin
            if (sel_valid) begin
               if (pick_free && sel_idx != first_q) begin
                  second_d            = sel_idx;
                  revealed_d[sel_idx] = 1'b1;
                  state_d             = S_CHECK;
               end else begin
                  sel_err_d = 1'b1;
               end
            end
         end
         S_CHECK: begin
            if (moves_q != '1) moves_d = moves_q + MOVE_W'(1);
            if (sym_first == sym_second) begin
               matched_d[first_q]  = 1'b1;
               matched_d[second_q] = 1'b1;
               for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                  if (player_q == PL_W'(p))
                     scores_d[p*SC_W +: SC_W] = scores_q[p*SC_W +: SC_W] + SC_W'(1);
               end
               state_d = (matched_d == '1) ? S_DONE : S_PICK1;
            end else begin
               cnt_d   = CNT_W'(REVEAL_CYCLES - 1);
               state_d = S_SHOW;
            end
         end
         S_SHOW: begin
            if (cnt_q == '0) begin
               revealed_d[first_q]  = 1'b0;
               revealed_d[second_q] = 1'b0;
               player_d = (player_q == PL_W'(NUM_PLAYERS - 1)) ? '0 : player_q + PL_W'(1);
               state_d  = S_PICK1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (quit) begin
         state_d    = S_IDLE;
         sym_d      = '0;
         first_d    = '0;
         second_d   = '0;
         cnt_d      = '0;
         revealed_d = '0;
         matched_d  = '0;
         moves_d    = '0;
         player_d   = '0;
         scores_d   = '0;
         sel_err_d  = 1'b0;
      end
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         sym_q      <= '0;
         first_q    <= '0;
         second_q   <= '0;
         cnt_q      <= '0;
         revealed_q <= '0;
         matched_q  <= '0;
         moves_q    <= '0;
         player_q   <= '0;
         scores_q   <= '0;
         sel_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sym_q      <= sym_d;
         first_q    <= first_d;
         second_q   <= second_d;
         cnt_q      <= cnt_d;
         revealed_q <= revealed_d;
         matched_q  <= matched_d;
         moves_q    <= moves_d;
         player_q   <= player_d;
         scores_q   <= scores_d;
         sel_err_q  <= sel_err_d;
      end
   end

   assign revealed  = revealed_q;
   assign matched   = matched_q;
   assign moves     = moves_q;
   assign player    = player_q;
   assign scores    = scores_q;
   assign sel_err   = sel_err_q;
   assign in_game   = (state_q == S_PICK1) || (state_q == S_PICK2) ||
                      (state_q == S_CHECK) || (state_q == S_SHOW);
   assign game_over = (state_q == S_DONE);

endmodule

// File: tb/tb_tile_match_engine.sv
// Testbench for tile_match_engine: directed game scenarios plus randomized
// play, checked against a behavioural model of the game rules.
module tb_tile_match_engine;

   localparam int NT = 4, SW = 2, NP = 2, RC = 4, MW = 8;
   localparam int IW = 2, PW = 1, SCW = 2;

   logic CLOCK_50 = 1'b0;
   logic resetn;
   logic start, quit, sel_valid;
   logic [IW-1:0]     sel_idx;
   logic [NT*SW-1:0]  tile_sym;
   logic [NT-1:0]     revealed, matched;
   logic [MW-1:0]     moves;
   logic [PW-1:0]     player;
   logic [NP*SCW-1:0] scores;
   logic in_game, game_over, sel_err;

   // second board with a non-power-of-two tile count
   logic       start6, quit6, sv6;
   logic [2:0] idx6;
   logic [17:0] sym6;
   logic [5:0] rev6, mat6;
   logic [7:0] moves6;
   logic [0:0] player6;
   logic [3:0] scores6;
   logic ig6, go6, err6;

   always #5 CLOCK_50 = ~CLOCK_50;

   tile_match_engine #(.NUM_TILES(NT), .SYM_W(SW), .MOVE_W(MW),
                       .NUM_PLAYERS(NP), .REVEAL_CYCLES(RC)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .quit(quit),
      .sel_valid(sel_valid), .sel_idx(sel_idx), .tile_sym(tile_sym),
      .revealed(revealed), .matched(matched), .moves(moves), .player(player),
      .scores(scores), .in_game(in_game), .game_over(game_over), .sel_err(sel_err));

   tile_match_engine #(.NUM_TILES(6), .SYM_W(3), .MOVE_W(8),
                       .NUM_PLAYERS(2), .REVEAL_CYCLES(4)) dut6 (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start6), .quit(quit6),
      .sel_valid(sv6), .sel_idx(idx6), .tile_sym(sym6),
      .revealed(rev6), .matched(mat6), .moves(moves6), .player(player6),
      .scores(scores6), .in_game(ig6), .game_over(go6), .sel_err(err6));

   int n_vec = 0, n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural model of the game rules ----------------
   typedef enum int {M_IDLE, M_PICK1, M_PICK2, M_CHECK, M_SHOW, M_DONE} mph_t;
   mph_t        m_ph;
   bit [NT-1:0] m_rev, m_mat;
   int          m_moves, m_player, m_first, m_second, m_show;
   int          m_sc[NP];
   int          m_sym[NT];
   bit          m_err;

   function automatic void model_clear();
      m_ph = M_IDLE; m_rev = '0; m_mat = '0; m_moves = 0; m_player = 0;
      m_first = 0; m_second = 0; m_show = 0; m_err = 0;
      foreach (m_sc[p]) m_sc[p] = 0;
      foreach (m_sym[i]) m_sym[i] = 0;
   endfunction

   function automatic void model_step(input bit st, input bit q, input bit sv,
                                      input int idx, input logic [NT*SW-1:0] ts);
      m_err = 0;
      if (q) begin
         model_clear();
         return;
      end
      case (m_ph)
         M_IDLE, M_DONE: if (st) begin
            for (int i = 0; i < NT; i++) m_sym[i] = int'(ts[i*SW +: SW]);
            m_rev = '0; m_mat = '0; m_moves = 0; m_player = 0;
            foreach (m_sc[p]) m_sc[p] = 0;
            m_ph = M_PICK1;
         end
         M_PICK1: if (sv) begin
            if (idx < NT && !m_mat[idx]) begin
               m_first = idx; m_rev[idx] = 1; m_ph = M_PICK2;
            end else m_err = 1;
         end
         M_PICK2: if (sv) begin
            if (idx < NT && !m_mat[idx] && idx != m_first) begin
               m_second = idx; m_rev[idx] = 1; m_ph = M_CHECK;
            end else m_err = 1;
         end
         M_CHECK: begin
            m_moves = (m_moves == 255) ? 255 : m_moves + 1;
            if (m_sym[m_first] == m_sym[m_second]) begin
               m_mat[m_first] = 1; m_mat[m_second] = 1;
               m_sc[m_player]++;
               m_ph = (m_mat == '1) ? M_DONE : M_PICK1;
            end else begin
               m_show = RC; m_ph = M_SHOW;
            end
         end
         M_SHOW: begin
            m_show--;
            if (m_show == 0) begin
               m_rev[m_first] = 0; m_rev[m_second] = 0;
               m_player = (m_player + 1) % NP;
               m_ph = M_PICK1;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic cmp_model(input string tag);
      logic [NP*SCW-1:0] esc;
      esc = '0;
      for (int p = 0; p < NP; p++) esc[p*SCW +: SCW] = SCW'(m_sc[p]);
      check({tag, ".revealed"},  32'(revealed),  32'(m_rev));
      check({tag, ".matched"},   32'(matched),   32'(m_mat));
      check({tag, ".moves"},     32'(moves),     32'(m_moves));
      check({tag, ".player"},    32'(player),    32'(m_player));
      check({tag, ".scores"},    32'(scores),    32'(esc));
      check({tag, ".in_game"},   32'(in_game),   32'(m_ph inside {M_PICK1, M_PICK2, M_CHECK, M_SHOW}));
      check({tag, ".game_over"}, 32'(game_over), 32'(m_ph == M_DONE));
      check({tag, ".sel_err"},   32'(sel_err),   32'(m_err));
   endtask

   // one clock of stimulus: drive at negedge, model the posedge, compare at next negedge
   task automatic cycle(input bit st, input bit q, input bit sv, input int idx);
      start = st; quit = q; sel_valid = sv; sel_idx = IW'(idx);
      @(posedge CLOCK_50);
      model_step(st, q, sv, idx, tile_sym);
      @(negedge CLOCK_50);
      cmp_model("cyc");
      start = 0; quit = 0; sel_valid = 0;
   endtask

   task automatic cycle6(input bit st, input bit sv, input int idx);
      start6 = st; sv6 = sv; idx6 = 3'(idx);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      start6 = 0; sv6 = 0;
   endtask

   localparam logic [NT*SW-1:0] BOARD = {2'd1, 2'd0, 2'd1, 2'd0};

   initial begin
      resetn = 0; start = 0; quit = 0; sel_valid = 0; sel_idx = '0; tile_sym = BOARD;
      start6 = 0; quit6 = 0; sv6 = 0; idx6 = '0;
      sym6 = {3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0};
      model_clear();
      repeat (2) @(negedge CLOCK_50);
      cmp_model("reset");
      resetn = 1;
      @(negedge CLOCK_50);

      // matching pair: tiles 0 and 2 share symbol 0
      cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 2);
      check("match.rev_before_check", 32'(revealed), 32'b0101);
      cycle(0, 0, 0, 0);
      check("match.matched", 32'(matched), 32'b0101);
      check("match.score0",  32'(scores[1:0]), 32'd1);
      check("match.moves",   32'(moves), 32'd1);
      check("match.player",  32'(player), 32'd0);

      // rejected picks: a matched tile, then the same tile twice
      cycle(0, 0, 1, 0);
      check("rej.matched_tile", 32'(sel_err), 32'd1);
      cycle(0, 0, 0, 0);
      check("rej.err_one_cycle", 32'(sel_err), 32'd0);
      cycle(0, 0, 1, 1);
      cycle(0, 0, 1, 1);
      check("rej.same_tile", 32'(sel_err), 32'd1);
      check("rej.stay_pick2", 32'(revealed), 32'b0111);

      // completion with tiles 1 and 3
      cycle(0, 0, 1, 3);
      cycle(0, 0, 0, 0);
      check("done.matched",   32'(matched), 32'b1111);
      check("done.game_over", 32'(game_over), 32'd1);
      check("done.in_game",   32'(in_game), 32'd0);
      check("done.score0",    32'(scores[1:0]), 32'd2);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // restart from DONE relatches symbols and clears the board
      tile_sym = {2'd0, 2'd0, 2'd1, 2'd1};
      cycle(1, 0, 0, 0);
      check("restart.matched", 32'(matched), 32'd0);
      tile_sym = BOARD;
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 1);
      cycle(0, 0, 0, 0);
      check("restart.relatched", 32'(matched), 32'b0011);
      cycle(0, 1, 0, 0);

      // mismatch: tiles 0 and 1 stay up for RC cycles after the check edge
      cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 1);
      cycle(0, 0, 0, 0);
      check("mis.show0", 32'(revealed), 32'b0011);
      for (int k = 0; k < RC - 1; k++) begin
         cycle(0, 0, k == 1, 2);
         check("mis.show", 32'(revealed), 32'b0011);
      end
      cycle(0, 0, 0, 0);
      check("mis.hidden", 32'(revealed), 32'b0000);
      check("mis.player", 32'(player), 32'd1);
      check("mis.moves",  32'(moves), 32'd1);

      // asynchronous reset while in PICK2
      cycle(0, 0, 1, 2);
      #2 resetn = 0;
      #1;
      check("areset.revealed", 32'(revealed), 32'd0);
      check("areset.moves",    32'(moves), 32'd0);
      check("areset.player",   32'(player), 32'd0);
      check("areset.in_game",  32'(in_game), 32'd0);
      model_clear();
      @(negedge CLOCK_50);
      resetn = 1;
      cycle(0, 0, 1, 1);

      // quit beats start in PICK1
      cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 2);
      cycle(0, 0, 0, 0);
      cycle(1, 1, 0, 0);
      check("prio.in_game", 32'(in_game), 32'd0);
      check("prio.matched", 32'(matched), 32'd0);
      cycle(0, 0, 1, 0);

      // randomized play
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) tile_sym = NT*SW'($urandom);
         cycle($urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0,
               $urandom_range(0, 1) == 1, int'($urandom_range(0, NT-1)));
      end

      // six-tile board: indices 6 and 7 do not exist, 5 does
      cycle6(1, 0, 0);
      check("b6.in_game", 32'(ig6), 32'd1);
      cycle6(0, 1, 6);
      check("b6.err_idx6", 32'(err6), 32'd1);
      cycle6(0, 1, 7);
      check("b6.err_idx7", 32'(err6), 32'd1);
      check("b6.rev_none", 32'(rev6), 32'd0);
      cycle6(0, 1, 5);
      check("b6.ok_idx5", 32'(err6), 32'd0);
      check("b6.rev5", 32'(rev6), 32'b100000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
